// File: rtl/finv_pkg.sv
// finv_pkg: fp32 field positions, constants and the in-flight tag type for finv_arbiter.
// Special-result tag fields exist only when FINV_ARB_SPECIAL_EN is defined.
package finv_pkg;

   localparam int FINV_LAT_DEF = 3;
   localparam int ID_W         = 3;

   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam int MAN_W   = 23;

   localparam logic [7:0]  EXP_MAX   = 8'hFF;
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   // id is sized for the largest supported requester count (8)
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
`ifdef FINV_ARB_SPECIAL_EN
      logic            spec_vld;
      logic [31:0]     spec_y;
`endif
   } finv_tag_t;

endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter; one-hot grant of the first request found searching
// upward from ptr with wrap, plus the binary index of that grant.
module rr_arb #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic          en,
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      if (en) begin
         for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
               any         = 1'b1;
               idx         = cand;
               grant[cand] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/finv_arbiter.sv
// finv_arbiter: round-robin sharing of one fixed-latency reciprocal pipeline among NREQ requesters.
// Optional FINV_ARB_SPECIAL_EN: zero/huge/inf/NaN operands bypass finv with a precomputed result.
module finv_arbiter
   import finv_pkg::*;
#(
   parameter  int NREQ     = 4,
   parameter  int FINV_LAT = FINV_LAT_DEF,
   localparam int IW       = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0][31:0] req_x,
   output logic [NREQ-1:0]       req_ready,
   output logic [31:0]           finv_x,
   input  logic [31:0]           finv_y,
   output logic                  rsp_valid,
   output logic [IW-1:0]         rsp_id,
   output logic [31:0]           rsp_y,
   output logic                  busy
);

   logic          arb_en;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant_idx;
   logic          transfer;
   logic          issue_vld;
   logic [IW-1:0] issue_id;
   finv_tag_t     tag_p [FINV_LAT];
   finv_tag_t     exit_tag;
   logic [31:0]   result_y;

`ifdef FINV_ARB_SPECIAL_EN
   logic          issue_spec_vld;
   logic [31:0]   issue_spec_y;
   logic [32:0]   spec_cls;

   // {hit, result}: operands whose reciprocal is inf, zero or NaN skip finv's answer
   function automatic logic [32:0] special_result(input logic [31:0] x);
      logic             s;
      logic [7:0]       e;
      logic [MAN_W-1:0] m;
      s = x[31];
      e = x[EXP_MSB:EXP_LSB];
      m = x[MAN_W-1:0];
      special_result = 33'd0;
      if (e == 8'd0)
         special_result = {1'b1, s, EXP_MAX, {MAN_W{1'b0}}};
      else if ((e == EXP_MAX - 8'd2) || (e == EXP_MAX - 8'd1))
         special_result = {1'b1, s, 31'd0};
      else if (e == EXP_MAX)
         special_result = (m != '0) ? {1'b1, FP32_QNAN} : {1'b1, s, 31'd0};
   endfunction

   assign spec_cls = special_result(req_x[grant_idx]);
`endif

   assign arb_en = en & ~rst;

   rr_arb #(.N(NREQ)) u_rr_arb (
      .en    (arb_en),
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (req_ready),
      .idx   (grant_idx),
      .any   (transfer)
   );

   // ---- issue stage: registered operand to finv ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         issue_vld <= 1'b0;
         issue_id  <= '0;
         finv_x    <= '0;
`ifdef FINV_ARB_SPECIAL_EN
         issue_spec_vld <= 1'b0;
         issue_spec_y   <= '0;
`endif
      end else begin
         issue_vld <= transfer;
         if (transfer) begin
            rr_ptr   <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
            issue_id <= grant_idx;
            finv_x   <= req_x[grant_idx];
`ifdef FINV_ARB_SPECIAL_EN
            issue_spec_vld <= spec_cls[32];
            issue_spec_y   <= spec_cls[31:0];
`endif
         end
      end
   end

   // ---- tag pipe: tracks the op inside finv, exit aligned with finv_y ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < FINV_LAT; k++)
            tag_p[k] <= '0;
      end else begin
         tag_p[0].vld <= issue_vld;
         tag_p[0].id  <= ID_W'(issue_id);
`ifdef FINV_ARB_SPECIAL_EN
         tag_p[0].spec_vld <= issue_spec_vld;
         tag_p[0].spec_y   <= issue_spec_y;
`endif
         for (int k = 1; k < FINV_LAT; k++)
            tag_p[k] <= tag_p[k-1];
      end
   end

   assign exit_tag = tag_p[FINV_LAT-1];

`ifdef FINV_ARB_SPECIAL_EN
   assign result_y = exit_tag.spec_vld ? exit_tag.spec_y : finv_y;
`else
   assign result_y = finv_y;
`endif

   // ---- response register: single broadcast port ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_y     <= '0;
      end else begin
         rsp_valid <= exit_tag.vld;
         if (exit_tag.vld) begin
            rsp_id <= IW'(exit_tag.id);
            rsp_y  <= result_y;
         end
      end
   end

   always_comb begin
      busy = issue_vld;
      for (int k = 0; k < FINV_LAT; k++)
         busy = busy | tag_p[k].vld;
   end

endmodule
